// File: rtl/sa_result_drain_if.sv
// Result stream bundle for sa_result_drain: valid/ready handshake carrying one
// accumulator element with its row/column tags and an end-of-matrix flag.
interface sa_result_drain_if #(
    parameter int OUT_WL = 8,
    parameter int RC_W   = 2
);
    logic              m_valid;
    logic              m_ready;
    logic [OUT_WL-1:0] m_data;
    logic [RC_W-1:0]   m_row;
    logic [RC_W-1:0]   m_col;
    logic              m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_row,
        output m_col,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_row,
        input  m_col,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/sa_result_drain.sv
// sa_result_drain: snapshots the systolic array's accumulator matrix when the
// array cycle counter reaches DONE_CYCLE, then streams it out row-major, one
// element per handshake, so the array can restart while the old result drains.
// Optional build macro SA_DRAIN_SAT_EN: saturate elements that do not fit in
// OUT_WL bits (and flag them on ovf) instead of truncating them.
module sa_result_drain #(
    parameter int SIZE       = 3,
    parameter int WL         = 8,
    parameter int NCOL_A     = 6,
    parameter int OUT_WL     = 8,
    parameter int DONE_CYCLE = NCOL_A + 2*SIZE - 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [SIZE*SIZE*2*WL-1:0]   out_flat,
    input  logic signed [31:0]          cycle_in,
    sa_result_drain_if.master           strm,
    output logic                        busy,
    output logic                        drop,
    output logic                        ovf
);
    localparam int          AW  = 2*WL;
    localparam int unsigned NEL = SIZE*SIZE;
    localparam int          IW  = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int          XW  = (NEL > 1) ? $clog2(NEL) : 1;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t          state;
    logic            done_q;
    logic            done_lvl;
    logic            done_rise;
    logic [XW-1:0]   idx;
    logic [XW-1:0]   idx_nx;
    logic [AW-1:0]   elem [NEL];
    logic [AW-1:0]   buff [NEL];

    // Width conversion of one accumulator; returns {ovf, data}.
    function automatic logic [OUT_WL:0] conv(input logic [AW-1:0] v);
`ifdef SA_DRAIN_SAT_EN
        if ((v >> OUT_WL) != '0)
            return {1'b1, {OUT_WL{1'b1}}};
        else
            return {1'b0, v[OUT_WL-1:0]};
`else
        return {1'b0, v[OUT_WL-1:0]};
`endif
    endfunction

    assign done_lvl  = (cycle_in == DONE_CYCLE);
    assign done_rise = done_lvl & ~done_q;
    assign idx_nx    = idx + 1'b1;

    // Unpack the flat accumulator bus into per-element words.
    always_comb begin
        for (int unsigned k = 0; k < NEL; k++) begin
            elem[k] = out_flat[k*AW +: AW];
        end
    end

    // Capture/stream controller; every stream output is registered so it holds
    // steady while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            done_q       <= 1'b0;
            idx          <= '0;
            strm.m_valid <= 1'b0;
            strm.m_data  <= '0;
            strm.m_row   <= '0;
            strm.m_col   <= '0;
            strm.m_last  <= 1'b0;
            busy         <= 1'b0;
            drop         <= 1'b0;
            ovf          <= 1'b0;
        end else begin
            done_q <= done_lvl;
            drop   <= 1'b0;
            case (state)
                IDLE: begin
                    if (done_rise) begin
                        for (int unsigned k = 0; k < NEL; k++) begin
                            buff[k] <= elem[k];
                        end
                        // First beat comes straight from the bus: the buffer
                        // is being written on this same edge.
                        {ovf, strm.m_data} <= conv(elem[0]);
                        idx          <= '0;
                        strm.m_row   <= '0;
                        strm.m_col   <= '0;
                        strm.m_last  <= 1'(NEL == 1);
                        strm.m_valid <= 1'b1;
                        busy         <= 1'b1;
                        state        <= STREAM;
                    end
                end
                STREAM: begin
                    if (done_rise) begin
                        drop <= 1'b1;
                    end
                    if (strm.m_valid && strm.m_ready) begin
                        if (strm.m_last) begin
                            strm.m_valid <= 1'b0;
                            strm.m_last  <= 1'b0;
                            busy         <= 1'b0;
                            ovf          <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            idx                <= idx_nx;
                            {ovf, strm.m_data} <= conv(buff[idx_nx]);
                            strm.m_last        <= (idx_nx == XW'(NEL - 1));
                            if (strm.m_col == IW'(SIZE - 1)) begin
                                strm.m_col <= '0;
                                strm.m_row <= strm.m_row + 1'b1;
                            end else begin
                                strm.m_col <= strm.m_col + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/sa_result_drain.md
Name: sa_result_drain

Overview:
- Downstream stage of the SIZE x SIZE output-stationary systolic array.
- Detects when the array's cycle counter reaches its terminal count and snapshots the full accumulator matrix into a local buffer.
- Streams the snapshot out one element per handshake, row-major, on a valid/ready interface with row/col tags and a last flag.
- Decouples the array from the consumer (writeback/DMA), so the array can be restarted while the previous result is still draining.

Parameters:
- SIZE, 3, array dimension (rows = cols of result).
- WL, 8, operand word length; accumulator width is 2*WL.
- NCOL_A, 6, inner dimension (columns of A / rows of B).
- OUT_WL, 8, width of streamed result element (OUT_WL <= 2*WL).
- DONE_CYCLE, NCOL_A+2*SIZE-2, array cycle count at which accumulators are final (10 at defaults).

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- out_flat  input  SIZE*SIZE*2*WL  array accumulators; element (i,j) at bits [(i*SIZE+j)*2*WL +: 2*WL].
- cycle_in  input  32  array cycle counter, signed integer.
- m_valid  output  1  stream data valid.
- m_ready  input  1  consumer ready.
- m_data  output  OUT_WL  result element.
- m_row  output  $clog2(SIZE)  row index of m_data.
- m_col  output  $clog2(SIZE)  column index of m_data.
- m_last  output  1  high on the final element (SIZE-1, SIZE-1).
- busy  output  1  snapshot held / streaming.
- drop  output  1  one-cycle pulse: new result completed while still streaming; that result is discarded.
- ovf  output  1  current m_data was clipped (see Optional Feature).

Behaviour:
- Reset is rst: synchronous, active-low; clock clk. All logic is posedge clk.
- Reset values: m_valid=0, m_data=0, m_row=0, m_col=0, m_last=0, busy=0, drop=0, ovf=0, state=IDLE, done_q=0, buffer contents don't-care.
- done_lvl = (cycle_in == DONE_CYCLE). done_q is the registered done_lvl. done_rise = done_lvl & ~done_q.
- States: IDLE and STREAM.
- IDLE:
  - On done_rise, latch all SIZE*SIZE accumulators from out_flat into the buffer on that edge.
  - Set idx=0 and go to STREAM.
  - m_valid rises on the cycle after cycle_in first equals DONE_CYCLE (1-cycle latency).
- STREAM:
  - m_valid=1 and busy=1.
  - m_data = conv(buf[idx]); m_row = idx / SIZE; m_col = idx % SIZE; m_last = (idx == SIZE*SIZE-1).
  - All outputs are registered and stay stable while m_valid && !m_ready (AXI-stream rule: no retraction, no data change).
  - On m_valid && m_ready, idx increments.
  - On the handshake with m_last=1, go to IDLE; m_valid and busy drop on the next cycle.
- Exactly SIZE*SIZE beats are produced per captured result.
- done_rise in STREAM: pulse drop for one cycle. The buffer and stream are unaffected, and the event is not queued.
- done_rise in the same cycle as the final handshake counts as STREAM, so drop pulses and the result is not captured.
- done_lvl held high does not retrigger; a new capture needs cycle_in to leave DONE_CYCLE and return.
- cycle_in changing or out_flat changing during STREAM has no effect on the streamed data.
- If cycle_in equals DONE_CYCLE at reset release, done_q=0 gives done_rise in the first cycle and a capture.
- rst low mid-stream: the stream aborts immediately and m_valid=0 next cycle; no partial-stream completion.
- conv(): 2*WL to OUT_WL, unsigned. The default is truncation to the low OUT_WL bits with ovf=0; see Optional Feature.

Optional Feature:
- Macro: SA_DRAIN_SAT_EN.
- Defined:
  - conv() saturates; any value >= 2^OUT_WL yields m_data = 2^OUT_WL-1.
  - ovf=1 for that beat and is registered alongside m_data.
- Undefined: conv() truncates to the low OUT_WL bits; ovf is tied to 0.

Test Plan:
- All out_flat elements = 6, cycle_in steps 0..10 -> m_valid rises the cycle after cycle_in=10; with m_ready=1, 9 consecutive beats of m_data=6, (row,col) (0,0)..(2,2), m_last only on beat 9, then m_valid=0.
- Elements = 11*i+j+1 (1..25 pattern), m_ready toggling 1,0,0,1 -> beats in row-major order; m_data/m_row/m_col held stable during every stall; exactly 9 handshakes.
- Element (1,2) = 300, OUT_WL=8 -> with SA_DRAIN_SAT_EN, beat 6 gives m_data=255, ovf=1; without it, m_data=44, ovf=0; all other beats ovf=0.
- During STREAM after beat 3, cycle_in goes 10->0->10 and out_flat changes -> drop pulses exactly one cycle; the remaining 6 beats carry the original snapshot; no second stream follows.
- cycle_in held at 10 for 30 cycles with m_ready=1 -> exactly one 9-beat stream and drop never asserts.
- rst=0 asserted during beat 5 -> m_valid, busy, m_last = 0 on the next cycle; after release with cycle_in=0, the block stays IDLE.
